// File: rtl/alu_fault_campaign_if.sv
// Control and result bundle between a campaign driver and the ALU stuck-at
// fault campaign engine.
interface alu_fault_campaign_if #(
    parameter int WIDTH        = 16,
    parameter int NUM_PATTERNS = 8
);
    localparam int FID_W = $clog2(4 * WIDTH);
    localparam int DP_W  = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
    localparam int CNT_W = $clog2(4 * WIDTH + 1);

    logic               start;
    logic               abort;
    logic [1:0]         alu_sel;
    logic [2*WIDTH-1:0] seed;
    logic               busy;
    logic               fault_valid;
    logic [FID_W-1:0]   fault_id;
    logic               fault_detected;
    logic [DP_W-1:0]    detect_pattern;
    logic [CNT_W-1:0]   detected_count;
    logic [CNT_W-1:0]   total_faults;
    logic               done;

    modport master (
        output start, abort, alu_sel, seed,
        input  busy, fault_valid, fault_id, fault_detected,
               detect_pattern, detected_count, total_faults, done
    );

    modport slave (
        input  start, abort, alu_sel, seed,
        output busy, fault_valid, fault_id, fault_detected,
               detect_pattern, detected_count, total_faults, done
    );
endinterface

// File: rtl/alu_fault_campaign.sv
// Self-running stuck-at fault campaign: every operand-pin fault is replayed
// over an LFSR pattern sequence against a golden ALU, with fault dropping.
module alu_fault_campaign #(
    parameter int                 WIDTH        = 16,
    parameter int                 NUM_PATTERNS = 8,
    parameter logic [2*WIDTH-1:0] LFSR_TAPS    = (2*WIDTH)'(32'h80200003)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_fault_campaign_if.slave  bus
);
    localparam int PW         = 2 * WIDTH;
    localparam int NUM_FAULTS = 4 * WIDTH;
    localparam int FID_W      = $clog2(NUM_FAULTS);
    localparam int DP_W       = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
    localparam int CNT_W      = $clog2(NUM_FAULTS + 1);
    localparam int IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [FID_W-1:0] LAST_FID  = FID_W'(NUM_FAULTS - 1);
    localparam logic [FID_W-1:0] B_BASE    = FID_W'(2 * WIDTH);
    localparam logic [DP_W-1:0]  LAST_PIDX = DP_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] TOTAL     = CNT_W'(NUM_FAULTS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_APPLY  = 3'd2,
        S_RECORD = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    function automatic logic [WIDTH:0] alu_f(input logic [1:0]       op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        case (op)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            2'b10:   r = {1'b0, a & b};
            2'b11:   r = {1'b0, a | b};
            default: r = {(WIDTH+1){1'b0}};
        endcase
        return r;
    endfunction

    function automatic logic [PW-1:0] lfsr_step(input logic [PW-1:0] x);
        return {1'b0, x[PW-1:1]} ^ (x[0] ? LFSR_TAPS : {PW{1'b0}});
    endfunction

    state_e           state_q, state_d;
    logic [PW-1:0]    lfsr_q, lfsr_d;
    logic [PW-1:0]    seed_q, seed_d;
    logic [1:0]       sel_q, sel_d;
    logic [DP_W-1:0]  pidx_q, pidx_d;
    logic [FID_W-1:0] fid_cur_q, fid_cur_d;
    logic             busy_q, busy_d;
    logic             fault_valid_q, fault_valid_d;
    logic [FID_W-1:0] fault_id_q, fault_id_d;
    logic             fault_detected_q, fault_detected_d;
    logic [DP_W-1:0]  detect_pattern_q, detect_pattern_d;
    logic [CNT_W-1:0] detected_count_q, detected_count_d;
    logic             done_q, done_d;

    logic             op_s;
    logic             sv_s;
    logic [FID_W-1:0] rem_s;
    logic [IDX_W-1:0] idx_s;
    logic [WIDTH-1:0] a_s, b_s, a_f_s, b_f_s;
    logic             mismatch_s;

    // Decode the current fault id and build the golden and faulty operands.
    always_comb begin
        op_s  = (fid_cur_q >= B_BASE);
        rem_s = op_s ? (fid_cur_q - B_BASE) : fid_cur_q;
        idx_s = rem_s[IDX_W:1];
        sv_s  = fid_cur_q[0];
        a_s   = lfsr_q[WIDTH-1:0];
        b_s   = lfsr_q[PW-1:WIDTH];
        a_f_s = a_s;
        b_f_s = b_s;
        if (op_s) begin
            b_f_s[idx_s] = sv_s;
        end else begin
            a_f_s[idx_s] = sv_s;
        end
        mismatch_s = (alu_f(sel_q, a_s, b_s) != alu_f(sel_q, a_f_s, b_f_s));
    end

    // Next-state and next-output logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d          = state_q;
        lfsr_d           = lfsr_q;
        seed_d           = seed_q;
        sel_d            = sel_q;
        pidx_d           = pidx_q;
        fid_cur_d        = fid_cur_q;
        busy_d           = busy_q;
        fault_valid_d    = 1'b0;
        fault_id_d       = fault_id_q;
        fault_detected_d = fault_detected_q;
        detect_pattern_d = detect_pattern_q;
        detected_count_d = detected_count_q;
        done_d           = 1'b0;
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d          = S_LOAD;
                        busy_d           = 1'b1;
                        sel_d            = bus.alu_sel;
                        seed_d           = (bus.seed == {PW{1'b0}}) ? {PW{1'b1}} : bus.seed;
                        fid_cur_d        = {FID_W{1'b0}};
                        detected_count_d = {CNT_W{1'b0}};
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    lfsr_d  = seed_q;
                    pidx_d  = {DP_W{1'b0}};
                    state_d = S_APPLY;
                end
                S_APPLY: begin
                    if (mismatch_s) begin
                        state_d          = S_RECORD;
                        fault_valid_d    = 1'b1;
                        fault_id_d       = fid_cur_q;
                        fault_detected_d = 1'b1;
                        detect_pattern_d = pidx_q;
                        detected_count_d = detected_count_q + CNT_W'(1);
                    end else if (pidx_q == LAST_PIDX) begin
                        state_d          = S_RECORD;
                        fault_valid_d    = 1'b1;
                        fault_id_d       = fid_cur_q;
                        fault_detected_d = 1'b0;
                        detect_pattern_d = {DP_W{1'b0}};
                    end else begin
                        lfsr_d = lfsr_step(lfsr_q);
                        pidx_d = pidx_q + DP_W'(1);
                    end
                end
                S_RECORD: begin
                    if (fid_cur_q == LAST_FID) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_LOAD;
                        fid_cur_d = fid_cur_q + FID_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            lfsr_q           <= {PW{1'b1}};
            seed_q           <= {PW{1'b1}};
            sel_q            <= 2'b00;
            pidx_q           <= {DP_W{1'b0}};
            fid_cur_q        <= {FID_W{1'b0}};
            busy_q           <= 1'b0;
            fault_valid_q    <= 1'b0;
            fault_id_q       <= {FID_W{1'b0}};
            fault_detected_q <= 1'b0;
            detect_pattern_q <= {DP_W{1'b0}};
            detected_count_q <= {CNT_W{1'b0}};
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            lfsr_q           <= lfsr_d;
            seed_q           <= seed_d;
            sel_q            <= sel_d;
            pidx_q           <= pidx_d;
            fid_cur_q        <= fid_cur_d;
            busy_q           <= busy_d;
            fault_valid_q    <= fault_valid_d;
            fault_id_q       <= fault_id_d;
            fault_detected_q <= fault_detected_d;
            detect_pattern_q <= detect_pattern_d;
            detected_count_q <= detected_count_d;
            done_q           <= done_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.fault_valid    = fault_valid_q;
    assign bus.fault_id       = fault_id_q;
    assign bus.fault_detected = fault_detected_q;
    assign bus.detect_pattern = detect_pattern_q;
    assign bus.detected_count = detected_count_q;
    assign bus.total_faults   = TOTAL;
    assign bus.done           = done_q;
endmodule

// File: tb/tb_alu_fault_campaign.sv
// Randomized self-checking bench for alu_fault_campaign: two instances
// (8 patterns and 1 pattern per fault) against a behavioural campaign model.
module tb_alu_fault_campaign;
    localparam int          W    = 16;
    localparam int          NF   = 4 * W;
    localparam logic [31:0] TAPS = 32'h80200003;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        use1;
    logic        start_s;
    logic        abort_s;
    logic [1:0]  sel_s;
    logic [31:0] seed_s;

    alu_fault_campaign_if #(.WIDTH(W), .NUM_PATTERNS(8)) if8 ();
    alu_fault_campaign_if #(.WIDTH(W), .NUM_PATTERNS(1)) if1 ();

    alu_fault_campaign #(.WIDTH(W), .NUM_PATTERNS(8), .LFSR_TAPS(TAPS)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8));
    alu_fault_campaign #(.WIDTH(W), .NUM_PATTERNS(1), .LFSR_TAPS(TAPS)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    assign if8.start   = start_s & ~use1;
    assign if8.abort   = abort_s & ~use1;
    assign if8.alu_sel = sel_s;
    assign if8.seed    = seed_s;
    assign if1.start   = start_s & use1;
    assign if1.abort   = abort_s & use1;
    assign if1.alu_sel = sel_s;
    assign if1.seed    = seed_s;

    logic       m_busy, m_valid, m_det, m_done;
    logic [5:0] m_id;
    logic [2:0] m_dp;
    logic [6:0] m_cnt;

    always_comb begin
        if (use1) begin
            m_busy = if1.busy; m_valid = if1.fault_valid; m_det = if1.fault_detected;
            m_done = if1.done; m_id = if1.fault_id; m_dp = {2'b00, if1.detect_pattern};
            m_cnt  = if1.detected_count;
        end else begin
            m_busy = if8.busy; m_valid = if8.fault_valid; m_det = if8.fault_detected;
            m_done = if8.done; m_id = if8.fault_id; m_dp = if8.detect_pattern;
            m_cnt  = if8.detected_count;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    int exp_det[NF];
    int exp_dp[NF];
    int exp_run[NF];
    int exp_busy;

    int obs_id[NF];
    int obs_det[NF];
    int obs_dp[NF];
    int obs_cnt[NF];
    int obs_n, obs_busy, obs_done, obs_done_busy, obs_timeout, obs_final_cnt;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? TAPS : 32'h0000_0000);
    endfunction

    // {cout, result} as a plain integer
    function automatic int alu_ref(input int sel, input int a, input int b);
        case (sel)
            0:       return a + b;
            1:       return a + (65535 - b) + 1;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic model_run(input int sel, input logic [31:0] seed, input int np);
        logic [31:0] x;
        int a, b, af, bf, op, idx, sv, run;
        run = 0;
        exp_busy = 1;
        for (int f = 0; f < NF; f++) begin
            op = f / (2 * W); idx = (f % (2 * W)) / 2; sv = f % 2;
            x = (seed == 32'h0000_0000) ? 32'hFFFF_FFFF : seed;
            exp_det[f] = 0; exp_dp[f] = 0;
            for (int p = 0; p < np; p++) begin
                a = int'(x[15:0]); b = int'(x[31:16]);
                af = a; bf = b;
                if (op == 0) af = (sv == 1) ? (a | (1 << idx)) : (a & ~(1 << idx));
                else         bf = (sv == 1) ? (b | (1 << idx)) : (b & ~(1 << idx));
                if (alu_ref(sel, a, b) != alu_ref(sel, af, bf)) begin
                    exp_det[f] = 1; exp_dp[f] = p;
                    break;
                end
                x = lfsr_next(x);
            end
            run += exp_det[f];
            exp_run[f] = run;
            exp_busy += 2 + ((exp_det[f] == 1) ? exp_dp[f] + 1 : np);
        end
    endtask

    // Runs one campaign on the selected instance and records what it reports.
    task automatic collect(input logic [1:0] sel, input logic [31:0] seed, input int restart_at);
        bit seen_busy;
        seen_busy = 1'b0;
        obs_n = 0; obs_busy = 0; obs_done = 0; obs_done_busy = 0; obs_timeout = 1;
        @(negedge clk);
        sel_s = sel; seed_s = seed; start_s = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            start_s = (c == restart_at);
            if (m_busy) begin
                obs_busy++; seen_busy = 1'b1;
            end else if (seen_busy) begin
                obs_timeout = 0;
                break;
            end
            if (m_valid) begin
                if (obs_n < NF) begin
                    obs_id[obs_n] = int'(m_id); obs_det[obs_n] = int'(m_det);
                    obs_dp[obs_n] = int'(m_dp); obs_cnt[obs_n] = int'(m_cnt);
                end
                obs_n++;
            end
            if (m_done) begin
                obs_done++;
                if (m_busy) obs_done_busy++;
            end
        end
        start_s = 1'b0;
        obs_final_cnt = int'(m_cnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; use1 = 1'b0; start_s = 1'b0; abort_s = 1'b0;
        sel_s = 2'b00; seed_s = 32'h0000_0000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({if8.busy, if8.fault_valid, if8.fault_detected, if8.done, if8.fault_id,
             if8.detect_pattern, if8.detected_count} !== 20'h0) begin
            n_bad++; $display("FAIL reset_outputs: got nonzero output vector, want all 0");
        end
        n_cmp++;
        if (if8.total_faults !== 7'd64 || if1.total_faults !== 7'd64) begin
            n_bad++; $display("FAIL reset_total: got %0d/%0d want 64", if8.total_faults, if1.total_faults);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_np1_and();
        int run;
        int want;
        use1 = 1'b1;
        collect(2'b10, 32'hFFFF_0000, -1);
        n_cmp++;
        if (obs_n !== 64 || obs_timeout !== 0) begin
            n_bad++; $display("FAIL and_strobes: got %0d timeout=%0d want 64", obs_n, obs_timeout);
        end
        n_cmp++;
        if (obs_final_cnt !== 16) begin
            n_bad++; $display("FAIL and_count: got %0d want 16", obs_final_cnt);
        end
        n_cmp++;
        if (obs_busy !== 193 || obs_done !== 1 || obs_done_busy !== 1) begin
            n_bad++; $display("FAIL and_timing: busy=%0d done=%0d want 193/1", obs_busy, obs_done);
        end
        run = 0;
        for (int n = 0; n < NF && n < obs_n; n++) begin
            want = (n < 32 && (n % 2) == 1) ? 1 : 0;
            run += want;
            n_cmp++;
            if (obs_id[n] !== n || obs_det[n] !== want || obs_cnt[n] !== run || obs_dp[n] !== 0) begin
                n_bad++;
                $display("FAIL and_fault[%0d]: got id=%0d det=%0d cnt=%0d want id=%0d det=%0d cnt=%0d",
                         n, obs_id[n], obs_det[n], obs_cnt[n], n, want, run);
            end
        end
        use1 = 1'b0;
    endtask

    task automatic test_np1_add();
        int want;
        use1 = 1'b1;
        collect(2'b00, 32'h0000_0000, -1);
        n_cmp++;
        if (obs_n !== 64 || obs_final_cnt !== 32 || obs_timeout !== 0) begin
            n_bad++; $display("FAIL add_count: got n=%0d cnt=%0d want 64/32", obs_n, obs_final_cnt);
        end
        for (int n = 0; n < NF && n < obs_n; n++) begin
            want = ((n % 2) == 0) ? 1 : 0;
            n_cmp++;
            if (obs_id[n] !== n || obs_det[n] !== want) begin
                n_bad++;
                $display("FAIL add_fault[%0d]: got id=%0d det=%0d want id=%0d det=%0d",
                         n, obs_id[n], obs_det[n], n, want);
            end
        end
        use1 = 1'b0;
    endtask

    // Random campaigns on the 8-pattern instance, with a start pulse while busy.
    task automatic test_campaigns();
        logic [1:0]  sel;
        logic [31:0] seed, x;
        int          want_p;
        for (int it = 0; it < 6; it++) begin
            sel  = (it == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            seed = (it == 0) ? 32'h0000_0000 : $urandom;
            model_run(int'(sel), seed, 8);
            collect(sel, seed, 20 + 7 * it);
            n_cmp++;
            if (obs_n !== 64 || obs_timeout !== 0 || obs_busy !== exp_busy ||
                obs_done !== 1 || obs_done_busy !== 1) begin
                n_bad++;
                $display("FAIL camp%0d_shape: got n=%0d busy=%0d done=%0d want 64/%0d/1",
                         it, obs_n, obs_busy, obs_done, exp_busy);
            end
            for (int n = 0; n < NF && n < obs_n; n++) begin
                n_cmp++;
                if (obs_id[n] !== n || obs_det[n] !== exp_det[n] || obs_dp[n] !== exp_dp[n] ||
                    obs_cnt[n] !== exp_run[n]) begin
                    n_bad++;
                    $display("FAIL camp%0d_fault[%0d]: got id=%0d det=%0d pat=%0d cnt=%0d want det=%0d pat=%0d cnt=%0d",
                             it, n, obs_id[n], obs_det[n], obs_dp[n], obs_cnt[n],
                             exp_det[n], exp_dp[n], exp_run[n]);
                end
            end
            if (it == 0) begin
                x = 32'hFFFF_FFFF; want_p = -1;
                for (int p = 0; p < 8; p++) begin
                    if (want_p < 0 && x[16] == 1'b0 && x[0] == 1'b1) want_p = p;
                    x = lfsr_next(x);
                end
                n_cmp++;
                if (obs_det[0] !== ((want_p < 0) ? 0 : 1) || (want_p >= 0 && obs_dp[0] !== want_p)) begin
                    n_bad++;
                    $display("FAIL or_id0: got det=%0d pat=%0d want first index %0d",
                             obs_det[0], obs_dp[0], want_p);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [1:0]  sel;
        logic [31:0] seed;
        int found, nv, nd, nb;
        sel = 2'($urandom_range(0, 3)); seed = $urandom;
        model_run(int'(sel), seed, 8);
        @(negedge clk);
        sel_s = sel; seed_s = seed; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        found = 0;
        for (int c = 0; c < 1000; c++) begin
            if (m_valid && m_id == 6'd5) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (found !== 1) begin
            n_bad++; $display("FAIL abort_reach: got found=%0d want 1", found);
        end
        abort_s = 1'b1;
        @(negedge clk);
        abort_s = 1'b0;
        n_cmp++;
        if (m_busy !== 1'b0) begin
            n_bad++; $display("FAIL abort_idle: got busy=%0d want 0", m_busy);
        end
        nv = 0; nd = 0; nb = 0;
        repeat (30) begin
            @(negedge clk);
            nv += int'(m_valid); nd += int'(m_done); nb += int'(m_busy);
        end
        n_cmp++;
        if (nv !== 0 || nd !== 0 || nb !== 0) begin
            n_bad++; $display("FAIL abort_quiet: got valid=%0d done=%0d busy=%0d want 0", nv, nd, nb);
        end
        n_cmp++;
        if (int'(m_cnt) !== exp_run[5]) begin
            n_bad++; $display("FAIL abort_count: got %0d want %0d", m_cnt, exp_run[5]);
        end
        collect(sel, seed, -1);
        n_cmp++;
        if (obs_n !== 64 || obs_id[0] !== 0 || obs_cnt[0] !== exp_run[0] ||
            obs_final_cnt !== exp_run[NF-1]) begin
            n_bad++;
            $display("FAIL abort_restart: got n=%0d id0=%0d cnt0=%0d final=%0d want 64/0/%0d/%0d",
                     obs_n, obs_id[0], obs_cnt[0], obs_final_cnt, exp_run[0], exp_run[NF-1]);
        end
    endtask

    task automatic test_start_abort_idle();
        int nb, held;
        held = int'(m_cnt);
        @(negedge clk);
        start_s = 1'b1; abort_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0; abort_s = 1'b0;
        nb = 0;
        repeat (5) begin
            nb += int'(m_busy) + int'(m_valid);
            @(negedge clk);
        end
        n_cmp++;
        if (nb !== 0 || int'(m_cnt) !== exp_run[NF-1] || held !== exp_run[NF-1]) begin
            n_bad++;
            $display("FAIL start_abort_idle: got activity=%0d cnt=%0d want 0/%0d", nb, m_cnt, exp_run[NF-1]);
        end
    endtask

    task automatic test_reset_mid();
        int seen, nb;
        @(negedge clk);
        sel_s = 2'b00; seed_s = $urandom; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        seen = 0;
        for (int c = 0; c < 500 && seen < 3; c++) begin
            if (m_valid) seen++;
            if (seen < 3) @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (m_busy !== 1'b1 || seen !== 3) begin
            n_bad++; $display("FAIL rstmid_setup: got busy=%0d strobes=%0d want 1/3", m_busy, seen);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({m_busy, m_valid, m_det, m_done, m_id, m_dp, m_cnt} !== 20'h0) begin
            n_bad++;
            $display("FAIL rstmid_clear: got busy=%0d id=%0d cnt=%0d want all 0", m_busy, m_id, m_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nb = 0;
        repeat (10) begin
            @(negedge clk);
            nb += int'(m_busy) + int'(m_valid) + int'(m_done);
        end
        n_cmp++;
        if (nb !== 0) begin
            n_bad++; $display("FAIL rstmid_idle: got activity=%0d want 0", nb);
        end
    endtask

    initial begin
        test_reset();
        test_np1_and();
        test_np1_add();
        test_campaigns();
        test_abort();
        test_start_abort_idle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_fault_campaign.md
# alu_fault_campaign

Self-running stuck-at fault campaign engine for the parametrised ALU. It walks every single stuck-at fault on the operand-A and operand-B input pins. For each fault it replays the same pseudo-random pattern sequence through a golden ALU model and a faulty ALU model, with fault dropping on first mismatch. It streams one result per fault and ends with a detected-fault count, giving on-chip ATPG coverage data for the datapath without an external tester.

## Interface
- WIDTH, 16: ALU operand width (≥2).
- NUM_PATTERNS, 8: maximum patterns applied per fault (≥1).
- LFSR_TAPS, 32'h80200003: Galois feedback mask for the 2*WIDTH-bit pattern LFSR.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin campaign; honoured only in IDLE.
- abort  in  1  stop campaign, return to IDLE, no done pulse.
- alu_sel  in  2  opcode; sampled at start, held for the whole campaign.
- seed  in  2*WIDTH  LFSR seed; low half is operand a, high half is operand b. Sampled at start. All-zero is replaced by all-ones.
- busy  out  1  high from the cycle after an accepted start until DONE.
- fault_valid  out  1  one-cycle strobe, one per fault.
- fault_id  out  $clog2(4*WIDTH)  fault under report: MSB = operand (0 A, 1 B), middle bits = bit index, LSB = stuck value.
- fault_detected  out  1  fault caused a mismatch.
- detect_pattern  out  $clog2(NUM_PATTERNS) (min 1)  index of the detecting pattern; 0 when undetected.
- detected_count  out  $clog2(4*WIDTH+1)  running count of detected faults.
- total_faults  out  $clog2(4*WIDTH+1)  constant 4*WIDTH.
- done  out  1  one-cycle pulse at campaign end.

## Operation
- Internal ALU model, shared encoding: 00 = a+b, cout = carry; 01 = a−b computed as a+~b+1, cout = carry; 10 = a&b, cout=0; 11 = a|b, cout=0. The comparison covers {cout, result}, WIDTH+1 bits.
- Fault injection: the faulty model sees the selected operand bit forced to the stuck value. All other bits pass through unchanged. The golden model sees unmodified operands.
- Fault order: fault_id increments from 0 to 4*WIDTH−1.
- State machine:
  - IDLE → LOAD on start.
  - LOAD: reload the LFSR from the latched seed; clear the pattern index.
  - LOAD → APPLY.
  - APPLY: one pattern per cycle, using the current LFSR value; compare the two models. On mismatch go to RECORD with detected=1. If the pattern index reaches NUM_PATTERNS−1 with no mismatch, go to RECORD with detected=0. Otherwise advance the LFSR and the index.
  - RECORD: assert fault_valid; update detected_count. Go to LOAD with the next fault, or to DONE after the last fault.
  - DONE: pulse done, then go to IDLE.
- The first pattern of every fault is the seed itself, so every fault sees an identical pattern sequence.
- abort in any non-IDLE state goes to IDLE next cycle. detected_count holds its partial value; no fault_valid or done is issued.
- start while busy is ignored. start and abort together in IDLE: abort wins and start is ignored.
- detected_count clears on an accepted start. It holds its value after DONE until the next start.

## Timing
- Reset: busy, fault_valid, fault_detected, done = 0; fault_id, detect_pattern, detected_count = 0; state = IDLE. LFSR reset value is all-ones. total_faults is constant.
- All outputs are registered. fault_valid and its fields are valid in the same cycle.
- Per-fault latency: 1 (LOAD) + k (APPLY, where k = detecting index + 1, or NUM_PATTERNS) + 1 (RECORD).
- Campaign length: start accepted at edge 0. busy rises at edge 1. done is high in the cycle after the last RECORD. busy falls with done.
- Worst case length: 4*WIDTH*(NUM_PATTERNS+2)+1 cycles.
- Reset mid-campaign clears everything immediately (asynchronous); no partial strobes.

## Test plan
- Reset during APPLY → all outputs zero in the same cycle. The block stays in IDLE until the next start.
- WIDTH=16, NUM_PATTERNS=1, alu_sel=10, seed=32'hFFFF_0000 → 64 fault_valid strobes. Only A stuck-at-1 faults (odd ids 1..31) are detected; detected_count=16; done after 193 cycles of busy.
- WIDTH=16, NUM_PATTERNS=1, alu_sel=00, seed=0 (replaced by all-ones, a=b=16'hFFFF) → every stuck-at-0 fault is detected and no stuck-at-1 fault is; detected_count=32.
- WIDTH=16, NUM_PATTERNS=8, alu_sel=11, seed=32'h0000_0000 replaced by all-ones → fault id 0 (A bit0 SA0) is undetected at pattern 0 and is then checked on advanced LFSR patterns. detect_pattern equals the first index where b[0]=0 and a[0]=1. Checked against the reference LFSR model.
- abort asserted at fault_id 5 → IDLE next cycle; no done; detected_count holds its partial value. A new start clears the count and restarts from id 0.
- start pulsed while busy, and start+abort together in IDLE → both start requests are ignored; no state change.
